// File: rtl/push_pull_status_fifo_pkg.sv
// Shared types and defaults for the push/pull status FIFO.
package push_pull_status_fifo_pkg;

  localparam int unsigned DEF_POINTER_BITS = 2;
  localparam int unsigned DEF_AF_LEVEL     = 3;

  typedef struct packed {
    logic ack;
    logic nack;
  } hs_rsp_t;

  // A request is either accepted or rejected, never both.
  function automatic hs_rsp_t hs_rsp(input logic req, input logic ok);
    hs_rsp_t r;
    r.ack  = req & ok;
    r.nack = req & ~ok;
    return r;
  endfunction

endpackage

// File: rtl/fifo_storage_ram.sv
// Depth x width register array: one synchronous write port, one registered read port.
module fifo_storage_ram #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 2
) (
  input  logic          clock,
  input  logic          clearN,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [2**AW];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read samples pre-edge contents, so a same-edge write to the head slot is not seen.
  always_ff @(posedge clock or negedge clearN) begin
    if (!clearN)   r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/push_pull_status_fifo_defs.sv
// Shared macros: logic levels, default word width and a clocked assertion helper.
`ifndef PUSH_PULL_STATUS_FIFO_DEFS_SV
`define PUSH_PULL_STATUS_FIFO_DEFS_SV

`define HIGH 1'b1
`define LOW  1'b0
`define DEFAULT_WORD_SIZE 8

`define ASSERT(name, clk, rstn, prop) \
  name: assert property (@(posedge clk) disable iff (!(rstn)) (prop));

`endif

// File: rtl/push_pull_status_fifo.sv
// Single-clock req/ack FIFO with push/pull nack, synchronous flush and occupancy status.
`ifndef PUSH_PULL_STATUS_FIFO_DEFS_SV
`include "push_pull_status_fifo_defs.sv"
`endif

module push_pull_status_fifo
  import push_pull_status_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WORD_SIZE    = `DEFAULT_WORD_SIZE,
  parameter int unsigned FIFO_POINTER_BITS = DEF_POINTER_BITS,
  parameter int unsigned ALMOST_FULL_LEVEL = DEF_AF_LEVEL
) (
  input  logic                       clock,
  input  logic                       clearN,
  input  logic                       flush,
  input  logic [FIFO_WORD_SIZE-1:0]  inValue,
  input  logic                       inReq,
  output logic                       inAck,
  output logic                       inNack,
  input  logic                       outReq,
  output logic [FIFO_WORD_SIZE-1:0]  outValue,
  output logic                       outAck,
  output logic                       outNack,
  output logic [FIFO_POINTER_BITS:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       almostFull
);

  localparam int unsigned PB    = FIFO_POINTER_BITS;
  localparam int unsigned DEPTH = 2**PB;
  localparam logic [PB:0] C_DEPTH = DEPTH[PB:0];
  localparam logic [PB:0] C_AF    = ALMOST_FULL_LEVEL[PB:0];
  localparam logic [PB:0] C_ONE   = (PB+1)'(1);

  logic [PB-1:0] r_wptr, r_rptr;
  logic [PB:0]   r_count, w_cnt_nxt;
  logic          r_empty, r_full, r_afull;
  hs_rsp_t       r_in_rsp, r_out_rsp, w_in_rsp, w_out_rsp;
  logic          w_push, w_pull;

  // Push into a full FIFO is legal only when the same edge frees the head slot.
  assign w_pull = outReq & ~flush & ~r_empty;
  assign w_push = inReq  & ~flush & (~r_full | w_pull);

  assign w_in_rsp  = hs_rsp(inReq,  w_push);
  assign w_out_rsp = hs_rsp(outReq, w_pull);

  always_comb begin
    w_cnt_nxt = r_count;
    if (flush)                 w_cnt_nxt = '0;
    else if (w_push & ~w_pull) w_cnt_nxt = r_count + C_ONE;
    else if (w_pull & ~w_push) w_cnt_nxt = r_count - C_ONE;
  end

  always_ff @(posedge clock or negedge clearN) begin
    if (!clearN) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_empty   <= `HIGH;
      r_full    <= `LOW;
      r_afull   <= `LOW;
      r_in_rsp  <= '0;
      r_out_rsp <= '0;
    end else begin
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pull) r_rptr <= r_rptr + 1'b1;
      end
      r_count   <= w_cnt_nxt;
      r_empty   <= (w_cnt_nxt == '0);
      r_full    <= (w_cnt_nxt == C_DEPTH);
      r_afull   <= (w_cnt_nxt >= C_AF);
      r_in_rsp  <= w_in_rsp;
      r_out_rsp <= w_out_rsp;
    end
  end

  fifo_storage_ram #(
    .W  (FIFO_WORD_SIZE),
    .AW (PB)
  ) u_ram (
    .clock   (clock),
    .clearN  (clearN),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (inValue),
    .i_re    (w_pull),
    .i_raddr (r_rptr),
    .o_rdata (outValue)
  );

  assign inAck      = r_in_rsp.ack;
  assign inNack     = r_in_rsp.nack;
  assign outAck     = r_out_rsp.ack;
  assign outNack    = r_out_rsp.nack;
  assign count      = r_count;
  assign empty      = r_empty;
  assign full       = r_full;
  assign almostFull = r_afull;

  `ASSERT(a_in_excl,  clock, clearN, !(inAck && inNack))
  `ASSERT(a_out_excl, clock, clearN, !(outAck && outNack))
  `ASSERT(a_cnt_rng,  clock, clearN, count <= C_DEPTH)

endmodule

// File: tb/tb_push_pull_status_fifo.sv
// Directed bench for push_pull_status_fifo with hand-computed expectations.
module tb_push_pull_status_fifo;

  logic       clock = 1'b0;
  logic       clearN, flush, inReq, outReq;
  logic [7:0] inValue;
  logic       inAck, inNack, outAck, outNack, empty, full, almostFull;
  logic [7:0] outValue;
  logic [2:0] count;

  int n_chk = 0;
  int n_err = 0;

  push_pull_status_fifo #(
    .FIFO_WORD_SIZE    (8),
    .FIFO_POINTER_BITS (2),
    .ALMOST_FULL_LEVEL (3)
  ) dut (
    .clock      (clock),
    .clearN     (clearN),
    .flush      (flush),
    .inValue    (inValue),
    .inReq      (inReq),
    .inAck      (inAck),
    .inNack     (inNack),
    .outReq     (outReq),
    .outValue   (outValue),
    .outAck     (outAck),
    .outNack    (outNack),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .almostFull (almostFull)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clocked transaction; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic ireq, input logic [7:0] ival, input logic oreq, input logic fl);
    inReq = ireq; inValue = ival; outReq = oreq; flush = fl;
    @(posedge clock); #1;
    inReq = 1'b0; outReq = 1'b0; flush = 1'b0;
  endtask

  // Full handshake/status snapshot in one call.
  task automatic snap(input string tag, input logic ia, input logic in_, input logic oa,
                      input logic on, input logic [2:0] c, input logic e, input logic f,
                      input logic af);
    chk({tag, ".inAck"},   inAck,   ia);
    chk({tag, ".inNack"},  inNack,  in_);
    chk({tag, ".outAck"},  outAck,  oa);
    chk({tag, ".outNack"}, outNack, on);
    chk({tag, ".count"},   count,   c);
    chk({tag, ".empty"},   empty,   e);
    chk({tag, ".full"},    full,    f);
    chk({tag, ".afull"},   almostFull, af);
  endtask

  logic [7:0] vec_a [4];

  initial begin
    vec_a[0] = 8'h11; vec_a[1] = 8'h22; vec_a[2] = 8'h33; vec_a[3] = 8'h44;
    clearN = 1'b0; flush = 1'b0; inReq = 1'b0; outReq = 1'b0; inValue = '0;
    repeat (2) @(posedge clock);
    #1;
    snap("reset", 0, 0, 0, 0, 3'd0, 1, 0, 0);
    chk("reset.outValue", outValue, 8'h00);
    clearN = 1'b1;

    // Fill 0x11..0x44, then drain in order.
    for (int i = 0; i < 4; i++) begin
      cyc(1, vec_a[i], 0, 0);
      snap($sformatf("push%0d", i), 1, 0, 0, 0, 3'(i + 1), 0, i == 3, i >= 2);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1, 0);
      snap($sformatf("pull%0d", i), 0, 0, 1, 0, 3'(3 - i), i == 3, 0, i == 0);
      chk($sformatf("pull%0d.val", i), outValue, vec_a[i]);
    end

    cyc(0, 8'h00, 1, 0);
    snap("pull_empty", 0, 0, 0, 1, 3'd0, 1, 0, 0);
    chk("pull_empty.val", outValue, 8'h44);

    for (int i = 0; i < 4; i++) cyc(1, vec_a[i], 0, 0);
    chk("refill.count", count, 3'd4);
    cyc(1, 8'h55, 0, 0);
    snap("push_full", 0, 1, 0, 0, 3'd4, 0, 1, 1);

    cyc(1, 8'hAA, 1, 0);
    snap("full_pp", 1, 0, 1, 0, 3'd4, 0, 1, 1);
    chk("full_pp.val", outValue, 8'h11);
    cyc(0, 8'h00, 1, 0); chk("drain0.val", outValue, 8'h22);
    cyc(0, 8'h00, 1, 0); chk("drain1.val", outValue, 8'h33);
    cyc(0, 8'h00, 1, 0); chk("drain2.val", outValue, 8'h44);
    cyc(0, 8'h00, 1, 0); chk("drain3.val", outValue, 8'hAA);
    chk("drain3.empty", empty, 1'b1);

    // Push+pull on empty: no bypass.
    cyc(1, 8'h5A, 1, 0);
    snap("empty_pp", 1, 0, 0, 1, 3'd1, 0, 0, 0);
    chk("empty_pp.val", outValue, 8'hAA);
    cyc(0, 8'h00, 1, 0);
    chk("empty_pp_next.val", outValue, 8'h5A);
    chk("empty_pp_next.ack", outAck, 1'b1);

    // Streaming through a one-deep occupancy wraps the pointers several times.
    cyc(1, 8'h01, 0, 0);
    for (int i = 2; i <= 12; i++) begin
      cyc(1, 8'(i), 1, 0);
      chk($sformatf("stream%0d.val", i), outValue, 8'(i - 1));
      chk($sformatf("stream%0d.count", i), count, 3'd1);
      chk($sformatf("stream%0d.acks", i), {inAck, outAck}, 2'b11);
    end
    cyc(0, 8'h00, 1, 0);
    chk("stream_last.val", outValue, 8'h0C);
    chk("stream_last.empty", empty, 1'b1);

    for (int i = 0; i < 3; i++) cyc(1, 8'hC0 + 8'(i), 0, 0);
    chk("preflush.afull", almostFull, 1'b1);
    cyc(1, 8'hEE, 1, 1);
    snap("flush", 0, 1, 0, 1, 3'd0, 1, 0, 0);
    chk("flush.val", outValue, 8'h0C);
    cyc(1, 8'h3C, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("postflush.val", outValue, 8'h3C);

    // Async reset mid-pull clears outputs without a clock edge.
    cyc(1, 8'h77, 0, 0);
    cyc(1, 8'h88, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("midpull.val", outValue, 8'h77);
    chk("midpull.count", count, 3'd1);
    #2 clearN = 1'b0;
    #1;
    snap("async_rst", 0, 0, 0, 0, 3'd0, 1, 0, 0);
    chk("async_rst.val", outValue, 8'h00);
    @(posedge clock); #1;
    clearN = 1'b1;
    cyc(1, 8'h99, 0, 0);
    chk("after_rst.inAck", inAck, 1'b1);
    cyc(0, 8'h00, 1, 0);
    chk("after_rst.val", outValue, 8'h99);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
